// File: rtl/counter_b4_monitor.sv
// Passive response checker for the 4-bit up/down/load counter; predicts each Q/load/rco from the previous command.
// Optional define B4_RCO_CHECK_EN adds the ripple-carry output to the mismatch condition.
module counter_b4_monitor #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 b4_clk,
  input  logic                 b4_reset_n,
  input  logic                 mon_reset,
  input  logic                 mon_enable,
  input  logic [1:0]           mon_mode,
  input  logic [WIDTH-1:0]     mon_D,
  input  logic [WIDTH-1:0]     mon_Q,
  input  logic                 mon_load,
  input  logic                 mon_rco,
  input  logic                 mon_clear,
  output logic                 chk_valid,
  output logic                 mismatch,
  output logic                 sticky_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     first_err_exp,
  output logic [WIDTH-1:0]     first_err_got
);

  localparam logic [1:0] MODE_ADD3 = 2'b00;
  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_INC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic             vld_p0;
  logic             cmd_reset_p0;
  logic             cmd_enable_p0;
  logic [1:0]       cmd_mode_p0;
  logic [WIDTH-1:0] cmd_d_p0;
  logic [WIDTH-1:0] q_prev_p0;

  logic [WIDTH-1:0] exp_q;
  logic             exp_load;
  logic             exp_rco;
  logic             diff;
  logic             hit;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + ERR_CNT_W'(1);
  endfunction

  // Reference model of the counter, evaluated on the command captured at the previous edge
  always_comb begin
    exp_q    = '0;
    exp_load = 1'b0;
    exp_rco  = 1'b0;
    if (!cmd_reset_p0 && cmd_enable_p0) begin
      case (cmd_mode_p0)
        MODE_ADD3: begin
          exp_q   = q_prev_p0 + WIDTH'(3);
          exp_rco = (q_prev_p0 >= ({WIDTH{1'b1}} - WIDTH'(2)));
        end
        MODE_DEC: begin
          exp_q   = q_prev_p0 - WIDTH'(1);
          exp_rco = (q_prev_p0 == '0);
        end
        MODE_INC: begin
          exp_q   = q_prev_p0 + WIDTH'(1);
          exp_rco = (&q_prev_p0);
        end
        MODE_LOAD: begin
          exp_q    = cmd_d_p0;
          exp_load = 1'b1;
        end
        default: exp_q = '0;
      endcase
    end
  end

`ifdef B4_RCO_CHECK_EN
  assign diff = (mon_Q != exp_q) || (mon_load != exp_load) || (mon_rco != exp_rco);
`else
  logic unused_rco;
  assign unused_rco = mon_rco ^ exp_rco;
  assign diff = (mon_Q != exp_q) || (mon_load != exp_load);
`endif

  assign hit = vld_p0 && diff;

  // Stage p0: command/Q capture; stage p1: comparison results and error status
  always_ff @(posedge b4_clk or negedge b4_reset_n) begin
    if (!b4_reset_n) begin
      vld_p0        <= 1'b0;
      cmd_reset_p0  <= 1'b0;
      cmd_enable_p0 <= 1'b0;
      cmd_mode_p0   <= '0;
      cmd_d_p0      <= '0;
      q_prev_p0     <= '0;
      chk_valid     <= 1'b0;
      mismatch      <= 1'b0;
      sticky_err    <= 1'b0;
      err_count     <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      vld_p0        <= 1'b1;
      cmd_reset_p0  <= mon_reset;
      cmd_enable_p0 <= mon_enable;
      cmd_mode_p0   <= mon_mode;
      cmd_d_p0      <= mon_D;
      q_prev_p0     <= mon_Q;
      chk_valid     <= vld_p0;
      mismatch      <= hit;
      if (mon_clear) begin
        // A mismatch on the clearing edge is recorded as the first error of the new window
        sticky_err    <= hit;
        err_count     <= hit ? ERR_CNT_W'(1) : '0;
        first_err_exp <= hit ? exp_q : '0;
        first_err_got <= hit ? mon_Q : '0;
      end else if (hit) begin
        sticky_err <= 1'b1;
        err_count  <= sat_inc(err_count);
        if (!sticky_err) begin
          first_err_exp <= exp_q;
          first_err_got <= mon_Q;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_b4_monitor.sv
// Directed bench for counter_b4_monitor: plays a counter's command/response stream with hand-computed responses.
module tb_counter_b4_monitor;

  logic       b4_clk = 1'b0;
  logic       b4_reset_n = 1'b0;
  logic       mon_reset = 1'b0;
  logic       mon_enable = 1'b0;
  logic [1:0] mon_mode = 2'b00;
  logic [3:0] mon_D = 4'h0;
  logic [3:0] mon_Q = 4'h0;
  logic       mon_load = 1'b0;
  logic       mon_rco = 1'b0;
  logic       mon_clear = 1'b0;
  logic       chk_valid;
  logic       mismatch;
  logic       sticky_err;
  logic [7:0] err_count;
  logic [3:0] first_err_exp;
  logic [3:0] first_err_got;

  int checks = 0;
  int failures = 0;

  counter_b4_monitor #(.WIDTH(4), .ERR_CNT_W(8)) dut (
    .b4_clk(b4_clk), .b4_reset_n(b4_reset_n),
    .mon_reset(mon_reset), .mon_enable(mon_enable), .mon_mode(mon_mode), .mon_D(mon_D),
    .mon_Q(mon_Q), .mon_load(mon_load), .mon_rco(mon_rco), .mon_clear(mon_clear),
    .chk_valid(chk_valid), .mismatch(mismatch), .sticky_err(sticky_err), .err_count(err_count),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  always #5 b4_clk = ~b4_clk;

  // Present a new command plus the counter's response to the previous command, then step one edge.
  task automatic drive_cyc(input logic rst, input logic en, input logic [1:0] mode, input logic [3:0] d,
                           input logic [3:0] q, input logic ld, input logic rco);
    mon_reset = rst; mon_enable = en; mon_mode = mode; mon_D = d;
    mon_Q = q; mon_load = ld; mon_rco = rco;
    @(posedge b4_clk);
    #1;
  endtask

  task automatic test_reset;
    b4_reset_n = 1'b0;
    #12;
    checks++;
    if ({chk_valid, mismatch, sticky_err, err_count, first_err_exp, first_err_got} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {chk_valid, mismatch, sticky_err, err_count, first_err_exp, first_err_got});
    end
    @(negedge b4_clk);
    b4_reset_n = 1'b1;
  endtask

  task automatic test_count_up;
    drive_cyc(1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0, 1'b0);
    checks++;
    if (chk_valid !== 1'b0) begin failures++; $display("FAIL up_first_edge chk_valid got=%b exp=0", chk_valid); end
    for (int i = 1; i <= 20; i++) begin
      drive_cyc(1'b0, 1'b1, 2'b10, 4'h0, 4'(i), 1'b0, (i % 16) == 0);
      checks++;
      if (chk_valid !== 1'b1 || mismatch !== 1'b0) begin
        failures++;
        $display("FAIL up_step i=%0d chk_valid=%b mismatch=%b exp chk_valid=1 mismatch=0", i, chk_valid, mismatch);
      end
    end
    checks++;
    if (err_count !== 8'd0) begin failures++; $display("FAIL up_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_load_add3;
    logic [3:0] q_exp [5];
    logic       l_exp [5];
    logic       r_exp [5];
    logic [1:0] m_cmd [5];
    q_exp = '{4'h5, 4'hA, 4'hD, 4'h0, 4'h3};
    l_exp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    r_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    m_cmd = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 5; i++) begin
      drive_cyc(1'b0, 1'b1, m_cmd[i], 4'hA, q_exp[i], l_exp[i], r_exp[i]);
      checks++;
      if (mismatch !== 1'b0) begin failures++; $display("FAIL load_add3 step=%0d mismatch got=%b exp=0", i, mismatch); end
    end
    checks++;
    if (err_count !== 8'd0 || sticky_err !== 1'b0) begin
      failures++;
      $display("FAIL load_add3_status err_count=%0d sticky=%b exp 0/0", err_count, sticky_err);
    end
  endtask

  task automatic test_forced_error;
    // Previous command was mode 00 from Q=3, so 6 is expected; 5 is presented.
    drive_cyc(1'b0, 1'b1, 2'b10, 4'h0, 4'h5, 1'b0, 1'b0);
    checks++;
    if (mismatch !== 1'b1 || sticky_err !== 1'b1 || err_count !== 8'd1 || first_err_exp !== 4'h6 || first_err_got !== 4'h5) begin
      failures++;
      $display("FAIL first_error mm=%b sticky=%b cnt=%0d exp_q=%h got_q=%h exp 1/1/1/6/5",
               mismatch, sticky_err, err_count, first_err_exp, first_err_got);
    end
    drive_cyc(1'b0, 1'b1, 2'b10, 4'h0, 4'h6, 1'b0, 1'b0);
    checks++;
    if (mismatch !== 1'b0 || sticky_err !== 1'b1 || err_count !== 8'd1) begin
      failures++;
      $display("FAIL error_pulse mm=%b sticky=%b cnt=%0d exp 0/1/1", mismatch, sticky_err, err_count);
    end
    drive_cyc(1'b0, 1'b1, 2'b10, 4'h0, 4'h9, 1'b0, 1'b0);
    checks++;
    if (mismatch !== 1'b1 || err_count !== 8'd2 || first_err_exp !== 4'h6 || first_err_got !== 4'h5) begin
      failures++;
      $display("FAIL second_error mm=%b cnt=%0d exp_q=%h got_q=%h exp 1/2/6/5", mismatch, err_count, first_err_exp, first_err_got);
    end
  endtask

  task automatic test_clear;
    mon_clear = 1'b1;
    drive_cyc(1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0, 1'b0);
    checks++;
    if (mismatch !== 1'b1 || sticky_err !== 1'b1 || err_count !== 8'd1 || first_err_exp !== 4'hA || first_err_got !== 4'h0) begin
      failures++;
      $display("FAIL clear_with_error mm=%b sticky=%b cnt=%0d exp_q=%h got_q=%h exp 1/1/1/A/0",
               mismatch, sticky_err, err_count, first_err_exp, first_err_got);
    end
    drive_cyc(1'b0, 1'b1, 2'b10, 4'h0, 4'h1, 1'b0, 1'b0);
    mon_clear = 1'b0;
    checks++;
    if (mismatch !== 1'b0 || chk_valid !== 1'b1 || sticky_err !== 1'b0 || err_count !== 8'd0 ||
        first_err_exp !== 4'h0 || first_err_got !== 4'h0) begin
      failures++;
      $display("FAIL clear_plain mm=%b vld=%b sticky=%b cnt=%0d exp_q=%h got_q=%h exp 0/1/0/0/0/0",
               mismatch, chk_valid, sticky_err, err_count, first_err_exp, first_err_got);
    end
  endtask

  task automatic test_saturation;
    // Q stuck at 3 under an increment command: every edge is an error.
    for (int i = 0; i < 300; i++) begin
      drive_cyc(1'b0, 1'b1, 2'b10, 4'h0, 4'h3, 1'b0, 1'b0);
      if (i == 253) begin
        checks++;
        if (err_count !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d exp=254", err_count); end
      end
    end
    checks++;
    if (err_count !== 8'd255 || mismatch !== 1'b1) begin
      failures++;
      $display("FAIL sat_255 cnt=%0d mm=%b exp 255/1", err_count, mismatch);
    end
    checks++;
    if (first_err_exp !== 4'h2 || first_err_got !== 4'h3) begin
      failures++;
      $display("FAIL sat_first exp_q=%h got_q=%h exp 2/3", first_err_exp, first_err_got);
    end
  endtask

  task automatic test_reset_mid;
    #2;
    b4_reset_n = 1'b0;
    #1;
    checks++;
    if ({chk_valid, mismatch, sticky_err, err_count, first_err_exp, first_err_got} !== 19'd0) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=0", {chk_valid, mismatch, sticky_err, err_count, first_err_exp, first_err_got});
    end
    #2;
    b4_reset_n = 1'b1;
    // Deliberately inconsistent Q: the first edge after release only captures.
    drive_cyc(1'b0, 1'b1, 2'b10, 4'h0, 4'h3, 1'b1, 1'b0);
    checks++;
    if (chk_valid !== 1'b0 || mismatch !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_edge1 vld=%b mm=%b exp 0/0", chk_valid, mismatch);
    end
    drive_cyc(1'b0, 1'b1, 2'b10, 4'h0, 4'h4, 1'b0, 1'b0);
    checks++;
    if (chk_valid !== 1'b1 || mismatch !== 1'b0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_edge2 vld=%b mm=%b cnt=%0d exp 1/0/0", chk_valid, mismatch, err_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] q_seq [6];
    logic       r_seq [6];
    logic       rs_cmd [6];
    logic       en_cmd [6];
    logic [1:0] m_cmd [6];
    // Responses: inc from 4, disabled, cmd reset, dec from 0 (wrap, rco), dec from 15, dec from 14
    q_seq  = '{4'h5, 4'h0, 4'h0, 4'hF, 4'hE, 4'hD};
    r_seq  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rs_cmd = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    en_cmd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    m_cmd  = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 6; i++) begin
      drive_cyc(rs_cmd[i], en_cmd[i], m_cmd[i], 4'h0, q_seq[i], 1'b0, r_seq[i]);
      checks++;
      if (mismatch !== 1'b0) begin failures++; $display("FAIL b2b step=%0d mismatch got=%b exp=0", i, mismatch); end
    end
    // Correct Q (12) but a spurious load flag must be caught.
    drive_cyc(1'b0, 1'b1, 2'b01, 4'h0, 4'hC, 1'b1, 1'b0);
    checks++;
    if (mismatch !== 1'b1 || err_count !== 8'd1 || first_err_exp !== 4'hC || first_err_got !== 4'hC) begin
      failures++;
      $display("FAIL b2b_load_flag mm=%b cnt=%0d exp_q=%h got_q=%h exp 1/1/C/C", mismatch, err_count, first_err_exp, first_err_got);
    end
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_load_add3;
    test_forced_error;
    test_clear;
    test_saturation;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
